// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
// Optional idle-owner timeout is enabled with the UART_ARB_TIMEOUT_EN macro.
package uart_arb_pkg;

  localparam int ARB_MAX_REQ = 16;
  localparam int ARB_MAX_IDXW = $clog2(ARB_MAX_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  // Index of the set bit in a one-hot vector; an all-zero vector maps to 0.
  function automatic logic [ARB_MAX_IDXW-1:0] oneHotToIdx(input logic [ARB_MAX_REQ-1:0] vec);
    logic [ARB_MAX_IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if (vec[i]) idx = ARB_MAX_IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans upward from the slot after the
// previous owner, wrapping modulo NUM_REQ, and returns a one-hot winner.
module rr_picker import uart_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [IDXW-1:0]    lastOwner,
  output logic [NUM_REQ-1:0] winner,
  output logic               anyReq
);

  // Walk the candidates in priority order; the first pending one wins.
  // The wrap is a conditional subtract so non-power-of-two counts stay correct.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    anyReq = |reqVec;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(lastOwner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && reqVec[idx[IDXW-1:0]]) begin
        winner[idx[IDXW-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter.
// Define UART_ARB_TIMEOUT_EN to abandon owners that stall in LOAD.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 250_000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 abort
);

  localparam int IDXW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : gBadNumReq
    $error("uart_tx_arbiter: NUM_REQ must be within 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t         state_q, state_d;
  logic [IDXW-1:0]    ownerIdx_q, ownerIdx_d;
  logic [IDXW-1:0]    lastOwner_q, lastOwner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         txData_q, txData_d;
  logic               txSend_q, txSend_d;
  logic               lastFlag_q, lastFlag_d;

  logic [NUM_REQ-1:0] pickOneHot;
  logic               pickAny;
  logic [IDXW-1:0]    pickIdx;
  logic [NUM_REQ-1:0] ownerOneHot;
  logic               ownerValid;
  logic               ownerLast;
  logic [7:0]         ownerData;
  logic               accept;
  logic               timeoutHit;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) uPicker (
    .reqVec    (req_valid),
    .lastOwner (lastOwner_q),
    .winner    (pickOneHot),
    .anyReq    (pickAny)
  );

  assign pickIdx = IDXW'(oneHotToIdx(ARB_MAX_REQ'(pickOneHot)));

  // Select the current owner's request lines out of the flattened buses.
  always_comb begin
    ownerOneHot = '0;
    ownerValid  = 1'b0;
    ownerLast   = 1'b0;
    ownerData   = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ownerIdx_q == IDXW'(i)) begin
        ownerOneHot[i] = 1'b1;
        ownerValid     = req_valid[i];
        ownerLast      = req_last[i];
        ownerData      = req_data[8*i +: 8];
      end
    end
  end

  // A byte is taken only from the owner, only in LOAD, and only when the UART is free.
  assign accept    = (state_q == LOAD) && ownerValid && !tx_busy;
  assign req_ready = accept ? ownerOneHot : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] toCnt_q, toCnt_d;
  logic          abort_q;

  assign timeoutHit = (state_q == LOAD) && !ownerValid &&
                      (toCnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Count idle LOAD cycles; any accept, timeout or exit from LOAD restarts it.
  always_comb begin
    toCnt_d = toCnt_q;
    if (state_q != LOAD || accept || timeoutHit) begin
      toCnt_d = '0;
    end else if (!ownerValid) begin
      toCnt_d = toCnt_q + TW'(1);
    end
  end

  // Timeout counter and the registered abort pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      toCnt_q <= '0;
      abort_q <= 1'b0;
    end else begin
      toCnt_q <= toCnt_d;
      abort_q <= timeoutHit;
    end
  end

  assign abort = abort_q;
`else
  assign timeoutHit = 1'b0;
  assign abort      = 1'b0;
`endif

  // Next-state logic: pick an owner, feed its bytes one frame at a time,
  // and release the grant once the last byte's frame has finished.
  always_comb begin
    state_d     = state_q;
    ownerIdx_d  = ownerIdx_q;
    lastOwner_d = lastOwner_q;
    grant_d     = grant_q;
    txData_d    = txData_q;
    txSend_d    = 1'b0;
    lastFlag_d  = lastFlag_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pickAny) begin
          ownerIdx_d = pickIdx;
          grant_d    = pickOneHot;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          txData_d   = ownerData;
          txSend_d   = 1'b1;
          lastFlag_d = ownerLast;
          state_d    = WAIT;
        end else if (timeoutHit) begin
          grant_d     = '0;
          lastOwner_d = ownerIdx_q;
          state_d     = IDLE;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (lastFlag_q) begin
            grant_d     = '0;
            lastOwner_d = ownerIdx_q;
            state_d     = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; the last-owner reset value gives requester 0 first turn.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ownerIdx_q  <= '0;
      lastOwner_q <= IDXW'(NUM_REQ - 1);
      grant_q     <= '0;
      txData_q    <= 8'h00;
      txSend_q    <= 1'b0;
      lastFlag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ownerIdx_q  <= ownerIdx_d;
      lastOwner_q <= lastOwner_d;
      grant_q     <= grant_d;
      txData_q    <= txData_d;
      txSend_q    <= txSend_d;
      lastFlag_q  <= lastFlag_d;
    end
  end

  assign grant   = grant_q;
  assign tx_data = txData_q;
  assign tx_send = txSend_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with three requesters.
// The timeout sequence is compiled in when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic        tx_done;
  logic        abort;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [2:0] mask;
    logic [7:0] base;
    logic [2:0] expGrant;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[9];

  uart_tx_arbiter #(
    .NUM_REQ        (3),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .abort     (abort)
  );

  // 25 MHz-style free-running clock (period is arbitrary in simulation).
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run always ends even if the design stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Drive all three requesters with one-byte packets: requester i presents base+i.
  task automatic applyStimulus(input logic [2:0] mask, input logic [7:0] base);
    req_valid = mask;
    req_last  = 3'b111;
    req_data  = {base + 8'd2, base + 8'd1, base};
  endtask

  // Idle for gap cycles, pulse tx_done for one cycle, return in the cycle after it.
  task automatic doneAfter(input int gap);
    repeat (gap) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    settle();
  endtask

  initial begin
    vecs[0] = '{3'b111, 8'hA0, 3'b001, 8'hA0};
    vecs[1] = '{3'b110, 8'hB0, 3'b010, 8'hB1};
    vecs[2] = '{3'b100, 8'hC0, 3'b100, 8'hC2};
    vecs[3] = '{3'b111, 8'hD0, 3'b001, 8'hD0};
    vecs[4] = '{3'b101, 8'hE0, 3'b100, 8'hE2};
    vecs[5] = '{3'b011, 8'h50, 3'b001, 8'h50};
    vecs[6] = '{3'b110, 8'h60, 3'b010, 8'h61};
    vecs[7] = '{3'b101, 8'h70, 3'b100, 8'h72};
    vecs[8] = '{3'b010, 8'h80, 3'b010, 8'h81};

    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;

    // Reset state while reset is held.
    repeat (2) tick();
    settle();
    checkOutput("reset grant", 32'(grant), 32'h0);
    checkOutput("reset req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset tx_send", 32'(tx_send), 32'h0);
    checkOutput("reset tx_data", 32'(tx_data), 32'h0);
    checkOutput("reset abort", 32'(abort), 32'h0);
    tick();
    reset_n = 1'b1;

    // Round-robin order over one-byte packets, including the wrap from 2 to 0.
    for (int v = 0; v < 9; v++) begin
      tick();
      applyStimulus(vecs[v].mask, vecs[v].base);
      settle();
      checkOutput($sformatf("vec%0d idle grant", v), 32'(grant), 32'h0);
      tick();
      settle();
      checkOutput($sformatf("vec%0d grant", v), 32'(grant), 32'(vecs[v].expGrant));
      checkOutput($sformatf("vec%0d req_ready", v), 32'(req_ready), 32'(vecs[v].expGrant));
      tick();
      req_valid = '0;
      settle();
      checkOutput($sformatf("vec%0d tx_send", v), 32'(tx_send), 32'h1);
      checkOutput($sformatf("vec%0d tx_data", v), 32'(tx_data), 32'(vecs[v].expData));
      checkOutput($sformatf("vec%0d abort", v), 32'(abort), 32'h0);
      doneAfter(2);
      checkOutput($sformatf("vec%0d released", v), 32'(grant), 32'h0);
    end

    // Single requester, three-byte packet 0x41 0x42 0x43.
    tick();
    req_valid = 3'b001;
    req_data  = {8'h00, 8'h00, 8'h41};
    req_last  = 3'b000;
    tick();
    settle();
    checkOutput("pkt grant b0", 32'(grant), 32'h1);
    checkOutput("pkt ready b0", 32'(req_ready), 32'h1);
    tick();
    req_data[7:0] = 8'h42;
    settle();
    checkOutput("pkt send b0", 32'(tx_send), 32'h1);
    checkOutput("pkt data b0", 32'(tx_data), 32'h41);
    checkOutput("pkt ready in WAIT", 32'(req_ready), 32'h0);
    doneAfter(9);
    checkOutput("pkt grant held", 32'(grant), 32'h1);
    checkOutput("pkt ready b1", 32'(req_ready), 32'h1);
    tick();
    req_data[7:0] = 8'h43;
    req_last      = 3'b001;
    settle();
    checkOutput("pkt send b1 two cycles after done", 32'(tx_send), 32'h1);
    checkOutput("pkt data b1", 32'(tx_data), 32'h42);
    doneAfter(9);
    checkOutput("pkt ready b2", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    req_last  = '0;
    settle();
    checkOutput("pkt send b2", 32'(tx_send), 32'h1);
    checkOutput("pkt data b2", 32'(tx_data), 32'h43);
    checkOutput("pkt grant before end", 32'(grant), 32'h1);
    doneAfter(9);
    checkOutput("pkt grant after end", 32'(grant), 32'h0);
    tick();
    settle();
    checkOutput("pkt grant stays clear", 32'(grant), 32'h0);
    checkOutput("pkt tx_send quiet", 32'(tx_send), 32'h0);

    // Requester 1 asks while requester 0 is mid-packet.
    tick();
    req_valid = 3'b001;
    req_data  = {8'h00, 8'h00, 8'h10};
    req_last  = 3'b000;
    tick();
    settle();
    checkOutput("hold grant0", 32'(grant), 32'h1);
    tick();
    req_valid = 3'b011;
    req_data  = {8'h00, 8'h20, 8'h11};
    req_last  = 3'b011;
    settle();
    checkOutput("hold send first", 32'(tx_data), 32'h10);
    checkOutput("hold ready in WAIT", 32'(req_ready), 32'h0);
    doneAfter(5);
    checkOutput("hold grant still 0", 32'(grant), 32'h1);
    checkOutput("hold ready only 0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b010;
    settle();
    checkOutput("hold send second", 32'(tx_send), 32'h1);
    checkOutput("hold data second", 32'(tx_data), 32'h11);
    checkOutput("hold no ready 1", 32'(req_ready), 32'h0);
    doneAfter(5);
    checkOutput("hold boundary idle", 32'(grant), 32'h0);
    tick();
    settle();
    checkOutput("hold next owner", 32'(grant), 32'h2);
    checkOutput("hold next ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    settle();
    checkOutput("hold next data", 32'(tx_data), 32'h20);
    doneAfter(3);

    // UART still busy on entry to LOAD.
    tick();
    req_valid = 3'b100;
    req_data  = {8'h55, 8'h00, 8'h00};
    req_last  = 3'b100;
    tx_busy   = 1'b1;
    tick();
    settle();
    checkOutput("busy grant", 32'(grant), 32'h4);
    checkOutput("busy no ready", 32'(req_ready), 32'h0);
    repeat (3) tick();
    settle();
    checkOutput("busy still no ready", 32'(req_ready), 32'h0);
    checkOutput("busy no send", 32'(tx_send), 32'h0);
    tick();
    settle();
    checkOutput("busy last cycle no send", 32'(tx_send), 32'h0);
    tick();
    tx_busy = 1'b0;
    settle();
    checkOutput("busy released ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    settle();
    checkOutput("busy send", 32'(tx_send), 32'h1);
    checkOutput("busy data", 32'(tx_data), 32'h55);
    doneAfter(3);

    // Asynchronous reset while waiting on a frame.
    tick();
    req_valid = 3'b001;
    req_data  = {8'h00, 8'h00, 8'h77};
    req_last  = 3'b000;
    tick();
    settle();
    checkOutput("rst grant", 32'(grant), 32'h1);
    tick();
    settle();
    checkOutput("rst send before", 32'(tx_send), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst async grant", 32'(grant), 32'h0);
    checkOutput("rst async tx_send", 32'(tx_send), 32'h0);
    checkOutput("rst async ready", 32'(req_ready), 32'h0);
    checkOutput("rst async tx_data", 32'(tx_data), 32'h0);
    tick();
    reset_n   = 1'b1;
    req_valid = '0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    settle();
    checkOutput("rst stray done grant", 32'(grant), 32'h0);
    checkOutput("rst stray done send", 32'(tx_send), 32'h0);
    tick();
    settle();
    checkOutput("rst stray done later", 32'(grant), 32'h0);

`ifdef UART_ARB_TIMEOUT_EN
    // Owner goes silent after a non-last byte; requester 2 is waiting.
    tick();
    req_valid = 3'b101;
    req_data  = {8'h33, 8'h00, 8'h31};
    req_last  = 3'b100;
    tick();
    settle();
    checkOutput("to grant0", 32'(grant), 32'h1);
    tick();
    req_valid = 3'b100;
    settle();
    checkOutput("to first data", 32'(tx_data), 32'h31);
    doneAfter(3);
    checkOutput("to load grant", 32'(grant), 32'h1);
    repeat (19) tick();
    settle();
    checkOutput("to no abort yet", 32'(abort), 32'h0);
    checkOutput("to grant before abort", 32'(grant), 32'h1);
    tick();
    settle();
    checkOutput("to abort pulse", 32'(abort), 32'h1);
    checkOutput("to grant cleared", 32'(grant), 32'h0);
    tick();
    settle();
    checkOutput("to abort single", 32'(abort), 32'h0);
    checkOutput("to next owner", 32'(grant), 32'h4);
    tick();
    req_valid = '0;
    settle();
    checkOutput("to next data", 32'(tx_data), 32'h33);
    doneAfter(3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter among `NUM_REQ` requesters (ATC status reporter, debug echo, command responder) on a packet basis. Round-robin arbitration selects an owner and keeps its grant until the owner's last byte has finished on the line. Bytes go to the transmitter one at a time: a `tx_send` pulse, then a wait for `tx_done`. The block sits between the requester logic and the UART TX datapath, which is clocked from the same 25 MHz `clock`.

## Interface
- `NUM_REQ`, 3: number of requesters; legal range 2..16.
- `TIMEOUT_CYCLES`, 250_000: idle-owner timeout in cycles (10 ms at 25 MHz). Used only with `UART_ARB_TIMEOUT_EN`.
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: requester i has a byte on `req_data[i]`.
- `req_data`  in  NUM_REQ×8: flattened byte bus; requester i on bits [8i+7:8i].
- `req_last`  in  NUM_REQ: the presented byte ends requester i's packet.
- `req_ready`  out  NUM_REQ: one-hot, combinational; the byte is consumed in the cycle `req_valid[i]` and `req_ready[i]` are both high.
- `grant`  out  NUM_REQ: one-hot owner, registered; all zero when no owner.
- `tx_data`  out  8: byte to transmit; registered and held until the next load.
- `tx_send`  out  1: one-cycle start pulse to the UART TX.
- `tx_busy`  in  1: the UART TX is shifting a frame.
- `tx_done`  in  1: one-cycle pulse from the UART TX after the stop bit.
- `abort`  out  1: one-cycle pulse when an owner times out. Tied to 0 when the feature is compiled out.

## Operation
- **States:** IDLE, LOAD, WAIT.
- **Reset values:** state IDLE; `grant`, `req_ready`, `tx_data`, `tx_send`, `abort` all 0; last-owner pointer = NUM_REQ-1, so requester 0 has first priority.
- **IDLE:**
  - `grant` = 0.
  - If any `req_valid`, the winner is the first set bit searching upward from (last_owner+1), wrapping modulo NUM_REQ.
  - Next state LOAD, owner <= winner.
- **LOAD:**
  - `grant` = onehot(owner).
  - If `req_valid[owner]` && !`tx_busy`:
    - `req_ready[owner]`=1;
    - `tx_data` <= `req_data[owner]`;
    - `tx_send` <= 1 (registered pulse);
    - last_flag <= `req_last[owner]`;
    - next state WAIT.
  - Otherwise stay in LOAD, grant held.
  - `req_valid` of non-owners is ignored.
- **WAIT:**
  - On `tx_done`: if last_flag, then last_owner <= owner and go to IDLE; otherwise go to LOAD.
  - Without `tx_done`, stay in WAIT.
- `tx_done` outside WAIT is ignored.
- `req_ready` is never high outside LOAD and never has more than one bit set.
- Owner index width is $clog2(NUM_REQ). Wrap arithmetic must be correct for non-power-of-two NUM_REQ: for NUM_REQ=3, index 2 + 1 gives 0.

## Timing
- `req_valid` rises in IDLE at cycle 0:
  - `grant` is high at cycle 1;
  - `req_ready` is high in cycle 1;
  - `tx_send` pulses in cycle 2 with `tx_data` valid.
- From `tx_done` in WAIT to the next `tx_send` of the same packet is 2 cycles, provided the owner holds `req_valid`.
- Packet boundary: `tx_done` of the last byte → IDLE next cycle → new `grant` the cycle after. Minimum two idle cycles between packets.
- Reset mid-packet: all outputs clear immediately. Any frame already in the UART completes on its own and its `tx_done` is ignored.
- `tx_busy` high on entry to LOAD (UART still finishing a frame): the block holds in LOAD without accepting the byte.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter runs in LOAD while `req_valid[owner]` is low, clearing on accept and on leaving LOAD.
  - When it reaches TIMEOUT_CYCLES-1, `abort` pulses for one cycle, the grant drops, last_owner <= owner, and the state goes to IDLE.
  - The partial packet is abandoned.
- Undefined: LOAD waits indefinitely, no counter logic is present, and `abort` is constant 0.

## Structure
- `uart_arb_pkg`: the `arb_state_t` enum (IDLE, LOAD, WAIT) and the constant `ARB_MAX_REQ`=16.
- Sub-module `rr_picker`: combinational. Takes the request vector and the last-owner index; returns a one-hot winner plus an any-request flag.
- The FSM, datapath registers and timeout counter stay in `uart_tx_arbiter`.

## Test plan
- **Single requester, 3-byte packet 0x41, 0x42, 0x43 (last on 0x43), `tx_done` modelled 10 cycles after each send:** expect 3 `tx_send` pulses with those bytes in order, `grant`=001 throughout, then `grant`=000.
- **All 3 request simultaneously from reset, each with a 1-byte packet:** grants in order 0, 1, 2. A repeat burst from all three grants 0 again after 2 (wrap).
- **Requester 0 mid-packet while requester 1 asserts `req_valid`:** `grant` stays 001 until 0's last byte `tx_done`; `req_ready[1]` is never high during that time.
- **`tx_busy` held high for 5 cycles on entry to LOAD:** no `req_ready` and no `tx_send` until `tx_busy` falls; the byte is accepted the following cycle.
- **`reset_n` pulsed low during WAIT:** `grant`, `tx_send` and `req_ready` go to 0 asynchronously. A stray `tx_done` afterwards produces no transition.
- **With `UART_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=20, owner drops `req_valid` after its first non-last byte:** `abort` pulses exactly 20 cycles into LOAD, `grant` clears, and the next pending requester wins.
